// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
// ---------------------------------------------------------------------------
// Error-metric collector for approximate multipliers. Each accepted sample
// (a, b, y_approx) flows through a three-stage pipeline. The stages are:
//   s1 : register the operands and the approximate product
//   s2 : recompute the exact product and register the error distance
//        |exact - y_approx|
//   s3 : fold the sample into saturating statistics
// A start/done controller (IDLE -> RUN -> DRAIN -> DONE) bounds each
// measurement to run_len samples.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, run_len    one-cycle run start pulse and the run's sample count
//   in_valid/in_ready sample handshake; in_ready depends only on the state,
//                     the accepted-sample count and the latched run length
//   a, b, y_approx    operands and the product returned by the design under test
//   busy, done        busy in RUN/DRAIN; done is a one-cycle pulse when the
//                     statistics are final
//   sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b
//                     run statistics, which hold until the next start or reset
// ---------------------------------------------------------------------------
module approx_mult_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int SUM_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   run_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2*W-1:0]     y_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   sum_ed,
  output logic [2*W-1:0]     max_ed,
  output logic [W-1:0]       max_a,
  output logic [W-1:0]       max_b
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The adder is wide enough for either operand plus a carry, so an
  // overflow past all-ones is visible before clamping.
  localparam int ADD_W = ((SUM_W > 2 * W) ? SUM_W : 2 * W) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  // Saturating increment: a full counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t             state_r;
  logic [CNT_W-1:0]   run_len_r;
  logic [CNT_W-1:0]   accept_cnt_r;
  logic               busy_r;
  logic               done_r;

  logic               s1_valid_r;
  logic [W-1:0]       s1_a_r;
  logic [W-1:0]       s1_b_r;
  logic [2*W-1:0]     s1_y_r;

  logic               s2_valid_r;
  logic [W-1:0]       s2_a_r;
  logic [W-1:0]       s2_b_r;
  logic [2*W-1:0]     s2_ed_r;

  logic [CNT_W-1:0]   sample_cnt_r;
  logic [CNT_W-1:0]   err_cnt_r;
  logic [SUM_W-1:0]   sum_ed_r;
  logic [2*W-1:0]     max_ed_r;
  logic [W-1:0]       max_a_r;
  logic [W-1:0]       max_b_r;

  logic               in_ready_s;
  logic               accept_s;
  logic               start_ok_s;
  logic [2*W-1:0]     exact_s;
  logic [2*W-1:0]     ed_s;
  logic [ADD_W-1:0]   sum_full_s;
  logic [SUM_W-1:0]   sum_next_s;

  // Handshake and start qualification; start only counts in IDLE or DONE.
  always_comb begin
    in_ready_s = 1'b0;
    start_ok_s = 1'b0;
    if (state_r == ST_RUN) begin
      in_ready_s = (accept_cnt_r < run_len_r);
    end else begin
      in_ready_s = 1'b0;
    end
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      start_ok_s = start;
    end else begin
      start_ok_s = 1'b0;
    end
    accept_s = in_valid & in_ready_s;
  end

  // Exact product and error distance; compare before subtracting so it never wraps.
  always_comb begin
    exact_s = {{W{1'b0}}, s1_a_r} * {{W{1'b0}}, s1_b_r};
    if (exact_s >= s1_y_r) begin
      ed_s = exact_s - s1_y_r;
    end else begin
      ed_s = s1_y_r - exact_s;
    end
  end

  // Saturating error-distance accumulation.
  always_comb begin
    sum_full_s = ADD_W'(sum_ed_r) + ADD_W'(s2_ed_r);
    if (sum_full_s > ADD_W'(SUM_MAX)) begin
      sum_next_s = SUM_MAX;
    end else begin
      sum_next_s = sum_full_s[SUM_W-1:0];
    end
  end

  // Run controller with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      run_len_r    <= {CNT_W{1'b0}};
      accept_cnt_r <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start_ok_s) begin
            state_r      <= ST_RUN;
            run_len_r    <= run_len;
            accept_cnt_r <= {CNT_W{1'b0}};
            busy_r       <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            accept_cnt_r <= accept_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          // A run with the full count moves to DRAIN on the next edge.
          if (accept_cnt_r == run_len_r) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!s1_valid_r && !s2_valid_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline stages s1 (capture) and s2 (error distance).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {W{1'b0}};
      s1_b_r     <= {W{1'b0}};
      s1_y_r     <= {(2*W){1'b0}};
      s2_valid_r <= 1'b0;
      s2_a_r     <= {W{1'b0}};
      s2_b_r     <= {W{1'b0}};
      s2_ed_r    <= {(2*W){1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r <= a;
        s1_b_r <= b;
        s1_y_r <= y_approx;
      end
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_a_r  <= s1_a_r;
        s2_b_r  <= s1_b_r;
        s2_ed_r <= ed_s;
      end
    end
  end

  // Statistics (stage s3): cleared by an accepted start, updated per s2 sample.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      sample_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r    <= {CNT_W{1'b0}};
      sum_ed_r     <= {SUM_W{1'b0}};
      max_ed_r     <= {(2*W){1'b0}};
      max_a_r      <= {W{1'b0}};
      max_b_r      <= {W{1'b0}};
    end else if (s2_valid_r) begin
      sample_cnt_r <= sat_inc(sample_cnt_r);
      if (s2_ed_r != {(2*W){1'b0}}) begin
        err_cnt_r <= sat_inc(err_cnt_r);
      end
      sum_ed_r <= sum_next_s;
      // Strictly greater: ties keep the earlier sample's operands.
      if (s2_ed_r > max_ed_r) begin
        max_ed_r <= s2_ed_r;
        max_a_r  <= s2_a_r;
        max_b_r  <= s2_b_r;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sample_cnt = sample_cnt_r;
  assign err_cnt    = err_cnt_r;
  assign sum_ed     = sum_ed_r;
  assign max_ed     = max_ed_r;
  assign max_a      = max_a_r;
  assign max_b      = max_b_r;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
module tb_approx_mult_err_monitor;

  localparam int W     = 16;
  localparam int CNT_W = 32;
  localparam int SUM_W = 34;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [2*W-1:0]   y_approx = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] sum_ed;
  logic [2*W-1:0]   max_ed;
  logic [W-1:0]     max_a;
  logic [W-1:0]     max_b;

  approx_mult_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .y_approx(y_approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] err;
    logic [SUM_W-1:0] sum;
    logic [2*W-1:0]   mx;
    logic [W-1:0]     ma;
    logic [W-1:0]     mb;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference statistics model
  logic [CNT_W-1:0] m_cnt, m_err;
  logic [SUM_W-1:0] m_sum;
  logic [2*W-1:0]   m_max;
  logic [W-1:0]     m_a, m_b;

  // Stimulus lists for feed()
  logic [W-1:0]   sa[$];
  logic [W-1:0]   sbv[$];
  logic [2*W-1:0] sy[$];

  task automatic model_clear();
    m_cnt = '0; m_err = '0; m_sum = '0; m_max = '0; m_a = '0; m_b = '0;
  endtask

  // Fold one accepted sample into the model; result is due 3 cycles later.
  task automatic model_accept(input logic [W-1:0] ia, input logic [W-1:0] ib,
                              input logic [2*W-1:0] iy);
    logic [2*W-1:0] ex, ed;
    logic [SUM_W:0] s;
    exp_t e;
    ex = {{W{1'b0}}, ia} * {{W{1'b0}}, ib};
    ed = (ex >= iy) ? (ex - iy) : (iy - ex);
    m_cnt = m_cnt + 1;
    if (ed != 0) m_err = m_err + 1;
    s = {1'b0, m_sum} + (SUM_W+1)'(ed);
    m_sum = s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    if (ed > m_max) begin m_max = ed; m_a = ia; m_b = ib; end
    e.due = cyc + 3; e.cnt = m_cnt; e.err = m_err; e.sum = m_sum;
    e.mx = m_max; e.ma = m_a; e.mb = m_b;
    sb_q.push_back(e);
  endtask

  // Advance one cycle, sample #1 after the edge, pop due scoreboard entries.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      n_tests++;
      if ({sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !==
          {e.cnt, e.err, e.sum, e.mx, e.ma, e.mb}) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d: got cnt=%0d err=%0d sum=%0h max=%0h a=%0d b=%0d expected cnt=%0d err=%0d sum=%0h max=%0h a=%0d b=%0d",
                 cyc, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b,
                 e.cnt, e.err, e.sum, e.mx, e.ma, e.mb);
      end
    end
  endtask

  // Pulse start in the current cycle t; returns t and checks cycle t+1.
  task automatic do_start(input int len, output int t);
    t = cyc;
    start = 1'b1; run_len = CNT_W'(len);
    model_clear();
    tick();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || sample_cnt !== '0 || sum_ed !== '0 || max_ed !== '0) begin
      n_fail++;
      $display("FAIL start_clear: got busy=%0b cnt=%0d sum=%0h max=%0h expected busy=1 and zero statistics",
               busy, sample_cnt, sum_ed, max_ed);
    end
  endtask

  // Feed the stimulus lists back to back; returns the last accept cycle.
  task automatic feed(output int last);
    last = -1;
    for (int i = 0; i < sa.size(); i++) begin
      in_valid = 1'b1; a = sa[i]; b = sbv[i]; y_approx = sy[i];
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL feed_ready[%0d]: got in_ready=%0b expected 1", i, in_ready);
      end else begin
        model_accept(sa[i], sbv[i], sy[i]);
        last = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    sa.delete(); sbv.delete(); sy.delete();
  endtask

  // Wait (bounded) for done; it must land at exp_cyc with busy low, then drop.
  task automatic wait_done(input int exp_cyc, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin seen = 1; break; end
      tick();
    end
    n_tests++;
    if (seen == 0 || cyc != exp_cyc || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got seen=%0d cycle=%0d busy=%0b expected done at cycle %0d with busy=0",
               name, seen, cyc, busy, exp_cyc);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: got done=%0b one cycle later expected 0", name, done);
    end
  endtask

  task automatic add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] iy);
    sa.push_back(ia); sbv.push_back(ib); sy.push_back(iy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({in_ready, busy, done, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%0b busy=%0b done=%0b cnt=%0d sum=%0h expected all 0",
               in_ready, busy, done, sample_cnt, sum_ed);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exact();
    int t, last;
    do_start(4, t);
    add(16'd3, 16'd5, 32'd15);
    add(16'd255, 16'd255, 32'd65025);
    add(16'd0, 16'd7, 32'd0);
    add(16'd65535, 16'd65535, 32'hFFFE0001);
    feed(last);
    wait_done(last + 4, "exact");
    n_tests++;
    if (sample_cnt !== 32'd4 || err_cnt !== 32'd0 || sum_ed !== 34'd0 || max_ed !== 32'd0) begin
      n_fail++;
      $display("FAIL exact_stats: got cnt=%0d err=%0d sum=%0d max=%0d expected 4 0 0 0",
               sample_cnt, err_cnt, sum_ed, max_ed);
    end
  endtask

  task automatic test_known_errors();
    int t, last;
    do_start(3, t);
    add(16'd10, 16'd10, 32'd96);
    add(16'd100, 16'd100, 32'd10008);
    add(16'd2, 16'd3, 32'd6);
    feed(last);
    wait_done(last + 4, "known");
    n_tests++;
    if (sample_cnt !== 32'd3 || err_cnt !== 32'd2 || sum_ed !== 34'd12 || max_ed !== 32'd8 ||
        max_a !== 16'd100 || max_b !== 16'd100) begin
      n_fail++;
      $display("FAIL known_stats: got cnt=%0d err=%0d sum=%0d max=%0d a=%0d b=%0d expected 3 2 12 8 100 100",
               sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b);
    end
  endtask

  task automatic test_tie_backpressure();
    int t, last, acc;
    do_start(2, t);
    acc = 0; last = -1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = (i == 0) ? 16'd4 : 16'd1;
      b = (i == 0) ? 16'd4 : 16'd1;
      y_approx = (i == 0) ? 32'd15 : 32'd0;
      if (in_ready === 1'b1) begin
        acc++;
        model_accept(a, b, y_approx);
        last = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (acc != 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure: got accepts=%0d in_ready=%0b expected 2 and 0", acc, in_ready);
    end
    wait_done(last + 4, "tie");
    n_tests++;
    if (max_a !== 16'd4 || max_b !== 16'd4 || max_ed !== 32'd1 || sum_ed !== 34'd2 || err_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL tie_keep_first: got a=%0d b=%0d max=%0d sum=%0d err=%0d expected 4 4 1 2 2",
               max_a, max_b, max_ed, sum_ed, err_cnt);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int t, last;
    do_start(0, t);
    wait_done(t + 3, "zero_len");
    n_tests++;
    if ({sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !== '0) begin
      n_fail++;
      $display("FAIL zero_len_stats: got cnt=%0d sum=%0h max=%0h expected all 0", sample_cnt, sum_ed, max_ed);
    end
    do_start(3, t);
    add(16'd7, 16'd7, 32'd50);
    add(16'd9, 16'd9, 32'd81);
    add(16'd3, 16'd3, 32'd0);
    feed(last);
    tick();                     // now in last+2, first DRAIN cycle
    start = 1'b1; run_len = 32'd1;
    tick();
    start = 1'b0;
    wait_done(last + 4, "ignored_start");
    n_tests++;
    if (sample_cnt !== 32'd3 || sum_ed !== 34'd10 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start: got cnt=%0d sum=%0d busy=%0b ready=%0b expected 3 10 0 0",
               sample_cnt, sum_ed, busy, in_ready);
    end
  endtask

  task automatic test_saturation();
    int t, last;
    do_start(7, t);
    for (int i = 0; i < 7; i++) add(16'd0, 16'd0, 32'hFFFFFFFF);
    feed(last);
    wait_done(last + 4, "sat");
    n_tests++;
    if (sum_ed !== 34'h3FFFFFFFF || max_ed !== 32'hFFFFFFFF || err_cnt !== 32'd7) begin
      n_fail++;
      $display("FAIL saturation: got sum=%0h max=%0h err=%0d expected 3ffffffff ffffffff 7",
               sum_ed, max_ed, err_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int t, last, saw_done;
    do_start(10, t);
    add(16'd6, 16'd6, 32'd30);
    add(16'd8, 16'd8, 32'd64);
    feed(last);                 // now at last+1
    tick();                     // last+2
    rst = 1'b1;
    sb_q.delete();
    model_clear();
    tick();
    n_tests++;
    if ({in_ready, busy, done, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got ready=%0b busy=%0b done=%0b cnt=%0d sum=%0h max=%0h expected all 0",
               in_ready, busy, done, sample_cnt, sum_ed, max_ed);
    end
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
      tick();
    end
    n_tests++;
    if (saw_done != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got done/busy activity=%0d expected 0", saw_done);
    end
    do_start(2, t);
    add(16'd12, 16'd12, 32'd140);
    add(16'd1, 16'd2, 32'd2);
    feed(last);
    wait_done(last + 4, "after_reset");
    n_tests++;
    if (sample_cnt !== 32'd2 || sum_ed !== 34'd4 || max_a !== 16'd12) begin
      n_fail++;
      $display("FAIL after_reset_stats: got cnt=%0d sum=%0d a=%0d expected 2 4 12",
               sample_cnt, sum_ed, max_a);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_exact();
    test_known_errors();
    test_tie_backpressure();
    test_zero_and_ignored_start();
    test_saturation();
    test_reset_mid_run();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
